// File: rtl/io_bridge_pkg.sv
// Shared types and default sizing for the CPU-to-peripheral IO bridge.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VGA_WAIT = 2'd1,
    RESP     = 2'd2
  } state_e;

  localparam int LED_W_DEF           = 16;
  localparam int SW_W_DEF            = 16;
  localparam int TIMEOUT_DEF         = 64;
  localparam int DEBOUNCE_CYCLES_DEF = 65536;
  localparam int VGA_AW              = 14;

endpackage

// File: rtl/io_bridge_sw_debounce.sv
// Switch input conditioning: 2-flop synchroniser, plus a stability filter
// when IO_SW_DEBOUNCE_EN is defined.
module sw_debounce
  import io_bridge_pkg::*;
#(
  parameter int SW_W = SW_W_DEF
`ifdef IO_SW_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] sw_o
);

  logic [SW_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SW_W-1:0] cand_q, out_q;
  logic [CW-1:0]   cnt_q;

  // cand_q tracks the last synced value; any change restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
    end else if (sync2_q != cand_q) begin
      cand_q <= sync2_q;
      cnt_q  <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      out_q <= cand_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sw_o = out_q;
`else
  assign sw_o = sync2_q;
`endif

endmodule

// File: rtl/io_bridge.sv
// CPU data-port to peripheral bridge (LED, switches, VGA with timeout).
// Optional switch debouncing is enabled by defining IO_SW_DEBOUNCE_EN.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int LED_W   = LED_W_DEF,
  parameter int SW_W    = SW_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
`ifdef IO_SW_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  input  logic              io_sel,
  input  logic              led_sel,
  input  logic              sw_sel,
  input  logic              vga_sel,
  output logic              ack,
  output logic              err,
  output logic [63:0]       rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw,
  output logic              vga_req,
  output logic              vga_we,
  output logic [VGA_AW-1:0] vga_addr,
  output logic [63:0]       vga_wdata,
  input  logic              vga_ack,
  input  logic [63:0]       vga_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [63:0]        rdata_q, rdata_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               vga_req_q, vga_req_d;
  logic               vga_we_q, vga_we_d;
  logic [VGA_AW-1:0]  vga_addr_q, vga_addr_d;
  logic [63:0]        vga_wdata_q, vga_wdata_d;
  logic [SW_W-1:0]    sw_val;
  logic               unused_addr;

  assign unused_addr = ^addr[63:VGA_AW];

  sw_debounce #(
    .SW_W(SW_W)
`ifdef IO_SW_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
  ) u_sw (
    .clk  (clk),
    .rst_n(rst_n),
    .sw_i (sw),
    .sw_o (sw_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      led_q       <= '0;
      vga_req_q   <= 1'b0;
      vga_we_q    <= 1'b0;
      vga_addr_q  <= '0;
      vga_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      led_q       <= led_d;
      vga_req_q   <= vga_req_d;
      vga_we_q    <= vga_we_d;
      vga_addr_q  <= vga_addr_d;
      vga_wdata_q <= vga_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    led_d       = led_q;
    vga_req_d   = vga_req_q;
    vga_we_d    = vga_we_q;
    vga_addr_d  = vga_addr_q;
    vga_wdata_d = vga_wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          vga_we_d    = we;
          vga_addr_d  = addr[VGA_AW-1:0];
          vga_wdata_d = wdata;
          err_d       = 1'b0;
          rdata_d     = '0;
          state_d     = RESP;
          if (io_sel && led_sel) begin
            if (we) led_d = wdata[LED_W-1:0];
            else    rdata_d = 64'(led_q);
          end else if (io_sel && sw_sel) begin
            if (!we) rdata_d = 64'(sw_val);
          end else if (io_sel && vga_sel) begin
            vga_req_d = 1'b1;
            cnt_d     = '0;
            state_d   = VGA_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      VGA_WAIT: begin
        // ack is checked first so a same-cycle ack beats the timeout
        if (vga_ack) begin
          vga_req_d = 1'b0;
          rdata_d   = vga_we_q ? 64'd0 : vga_rdata;
          err_d     = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          vga_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ack       = (state_q == RESP);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign led       = led_q;
  assign vga_req   = vga_req_q;
  assign vga_we    = vga_we_q;
  assign vga_addr  = vga_addr_q;
  assign vga_wdata = vga_wdata_q;

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: stimulus pushes expected responses, a monitor checks each ack.
module tb_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic        io_sel = 1'b0, led_sel = 1'b0, sw_sel = 1'b0, vga_sel = 1'b0;
  logic        ack, err;
  logic [63:0] rdata;
  logic [15:0] led;
  logic [15:0] sw = 16'h00F0;
  logic        vga_req, vga_we;
  logic [13:0] vga_addr;
  logic [63:0] vga_wdata;
  logic        vga_ack = 1'b0;
  logic [63:0] vga_rdata = '0;

  typedef struct {
    logic [63:0] rd;
    logic        er;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  io_bridge #(
    .TIMEOUT(8)
`ifdef IO_SW_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .io_sel(io_sel), .led_sel(led_sel), .sw_sel(sw_sel), .vga_sel(vga_sel),
    .ack(ack), .err(err), .rdata(rdata), .led(led), .sw(sw),
    .vga_req(vga_req), .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata),
    .vga_ack(vga_ack), .vga_rdata(vga_rdata)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end else begin
      $display("[TB] ok   %s = %h", nm, act);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got rdata %h err %b expected no ack", rdata, err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rdata !== e.rd || err !== e.er) begin
          n_fail++;
          $display("FAIL %s: got rdata %h err %b expected rdata %h err %b",
                   e.nm, rdata, err, e.rd, e.er);
        end else begin
          $display("[TB] txn  %s rdata=%h err=%b", e.nm, rdata, err);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic io, input logic l, input logic s, input logic v);
    req = 1'b1; we = w; addr = a; wdata = d;
    io_sel = io; led_sel = l; sw_sel = s; vga_sel = v;
  endtask

  task automatic release_req();
    req = 1'b0; io_sel = 1'b0; led_sel = 1'b0; sw_sel = 1'b0; vga_sel = 1'b0;
  endtask

  // Local transaction: req sampled at edge N, ack only in cycle N+1.
  task automatic local_txn(input string nm, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input logic io, input logic l,
                           input logic s, input logic v,
                           input logic [63:0] exp_rd, input logic exp_er);
    exp_t e;
    @(posedge clk); #1;
    drive(w, a, d, io, l, s, v);
    e.rd = exp_rd; e.er = exp_er; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
    release_req();
    @(negedge clk);
    check({nm, "_ack_n1"}, 64'(ack), 64'd1);
    @(negedge clk);
    check({nm, "_ack_pulse"}, 64'(ack), 64'd0);
  endtask

  // Starts a VGA access and returns just after edge N with req released.
  task automatic vga_start(input string nm, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input logic push,
                           input logic [63:0] exp_rd, input logic exp_er);
    exp_t e;
    @(posedge clk); #1;
    drive(w, a, d, 1'b1, 1'b0, 1'b0, 1'b1);
    if (push) begin
      e.rd = exp_rd; e.er = exp_er; e.nm = nm;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    release_req();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_led", 64'(led), 64'd0);
    check("rst_vga_req", 64'(vga_req), 64'd0);

    // LED write then read
    local_txn("led_wr", 1'b1, 64'h10, 64'h1234_A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    check("led_value", 64'(led), 64'h0000_A5A5);
    local_txn("led_rd", 1'b0, 64'h10, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0000_A5A5, 1'b0);

    // Switch read after the synchroniser (and debouncer) has settled
    repeat (10) @(posedge clk);
    local_txn("sw_rd", 1'b0, 64'h20, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h00F0, 1'b0);
    local_txn("sw_wr_ignored", 1'b1, 64'h20, 64'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
`ifdef IO_SW_DEBOUNCE_EN
    @(posedge clk); #1 sw = 16'h000F;
    repeat (2) @(posedge clk);
    #1 sw = 16'h00F0;
    repeat (12) @(posedge clk);
    local_txn("sw_glitch", 1'b0, 64'h20, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h00F0, 1'b0);
`endif
    @(posedge clk); #1 sw = 16'h000F;
    repeat (12) @(posedge clk);
    local_txn("sw_change", 1'b0, 64'h20, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h000F, 1'b0);

    // Priority led over sw, unmapped accesses leave led alone
    local_txn("prio_led", 1'b0, 64'h10, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_A5A5, 1'b0);
    local_txn("unmapped", 1'b1, 64'h30, 64'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    local_txn("io_sel_low", 1'b1, 64'h10, 64'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    check("led_unchanged", 64'(led), 64'h0000_A5A5);

    // VGA read, ack sampled 5 edges after acceptance
    vga_start("vga_rd", 1'b0, 64'hFFFF_0000_0000_2ABC, 64'h0, 1'b1, 64'hDEAD, 1'b0);
    check("vga_addr", 64'(vga_addr), 64'h2ABC);
    check("vga_we_rd", 64'(vga_we), 64'd0);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vga_req) hi++;
      if (i == 4) begin vga_ack = 1'b1; vga_rdata = 64'hDEAD; end
    end
    @(posedge clk); #1 vga_ack = 1'b0;
    check("vga_req_cycles", 64'(hi), 64'd5);
    @(negedge clk);
    check("vga_rd_ack", 64'(ack), 64'd1);
    check("vga_req_drop", 64'(vga_req), 64'd0);

    // VGA write with immediate ack; rdata must not pick up vga_rdata
    vga_start("vga_wr", 1'b1, 64'h0155, 64'hCAFE_F00D_1234_5678, 1'b1, 64'd0, 1'b0);
    check("vga_wdata", vga_wdata, 64'hCAFE_F00D_1234_5678);
    check("vga_we_wr", 64'(vga_we), 64'd1);
    vga_ack = 1'b1; vga_rdata = 64'hBAD0;
    @(posedge clk); #1 vga_ack = 1'b0;
    @(negedge clk);
    check("vga_wr_ack", 64'(ack), 64'd1);

    // VGA timeout
    vga_start("vga_timeout", 1'b0, 64'h0200, 64'h0, 1'b1, 64'd0, 1'b1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!vga_req) break;
      hi++;
    end
    check("timeout_cycles", 64'(hi), 64'd8);
    check("timeout_ack", 64'(ack), 64'd1);

    // Ack on the same edge the counter expires: ack wins
    vga_start("ack_vs_timeout", 1'b0, 64'h0300, 64'h0, 1'b1, 64'h0000_0000_0000_BEEF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) begin vga_ack = 1'b1; vga_rdata = 64'hBEEF; end
    end
    @(posedge clk); #1 vga_ack = 1'b0;
    @(negedge clk);
    check("ack_vs_timeout_ack", 64'(ack), 64'd1);

    // Reset in the middle of VGA_WAIT
    vga_start("vga_abort", 1'b0, 64'h0400, 64'h0, 1'b0, 64'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_pre_req", 64'(vga_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_vga_req", 64'(vga_req), 64'd0);
    check("abort_ack", 64'(ack), 64'd0);
    check("abort_led", 64'(led), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_vga_req", 64'(vga_req), 64'd0);
    check("post_rst_ack", 64'(ack), 64'd0);
    local_txn("post_rst_led_rd", 1'b0, 64'h10, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
# io_bridge

Single-cycle-handshake bridge between the CPU data-memory port and the on-board peripherals (LED register, switch input, VGA port). It sits directly downstream of the system address decoder and consumes its io/led/sw/vga select lines. It sequences one IO transaction at a time and owns the LED register and switch synchroniser. It forwards VGA accesses over a req/ack port with timeout, and returns read data plus an error flag to the CPU.

## Interface
- LED_W, 16: LED register width.
- SW_W, 16: switch input width.
- TIMEOUT, 64: max cycles waiting for vga_ack before error (≥1).
- DEBOUNCE_CYCLES, 65536: stable cycles required by the debouncer (only with macro).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  CPU IO request; addr/we/wdata valid while high.
- we  in  1  1 = write, 0 = read.
- addr  in  64  request address; bits 13:0 forwarded to VGA.
- wdata  in  64  write data.
- io_sel, led_sel, sw_sel, vga_sel  in  1 each  decoder outputs for addr.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = unmapped or timed out.
- rdata  out  64  read data, valid with ack.
- led  out  LED_W  LED register.
- sw  in  SW_W  raw asynchronous switch inputs.
- vga_req  out  1  VGA request, held until vga_ack or timeout.
- vga_we  out  1  VGA write strobe qualifier.
- vga_addr  out  14  addr[13:0] captured at accept.
- vga_wdata  out  64  captured wdata.
- vga_ack  in  1  VGA completion; vga_rdata valid same cycle.
- vga_rdata  in  64  VGA read data.

## Operation
- States: IDLE, VGA_WAIT, RESP.
- IDLE: on req=1, capture we/addr/wdata and selects. Priority led_sel > sw_sel > vga_sel.
  - led: write loads led ← wdata[LED_W-1:0]; read returns zero-extended led. → RESP.
  - sw: read returns zero-extended switch value; write is ignored, err=0. → RESP.
  - vga: assert vga_req, clear timeout counter. → VGA_WAIT.
  - io_sel=0, or no peripheral select: rdata=0, err=1. → RESP.
- VGA_WAIT: counter increments each cycle.
  - vga_ack=1: drop vga_req, latch vga_rdata (reads), err=0. → RESP.
  - Counter reaches TIMEOUT without ack: drop vga_req, rdata=0, err=1. → RESP.
  - vga_ack and timeout in the same cycle: ack wins, err=0.
- RESP: ack=1 for exactly one cycle → IDLE. rdata/err hold until the next ack.
- Requester must deassert req, or present a new transaction, in the cycle after ack. req is only sampled in IDLE.
- Switch path: 2-flop synchroniser on sw, always present.
- Reset values: state IDLE; ack, err, vga_req, vga_we = 0; rdata, led, vga_addr, vga_wdata = 0; synchroniser and counters = 0.
- Reset mid-transaction aborts it; vga_req falls asynchronously.

## Timing
- Local (led/sw/unmapped): req sampled high at edge N → ack high in cycle N+1 → IDLE at N+2.
- LED output updates at edge N.
- VGA: vga_req high from edge N until the edge vga_ack is sampled (edge M); ack high in cycle M+1.
- Timeout: vga_req drops TIMEOUT cycles after assertion; ack+err follow one cycle later.
- Switch latency: 2 cycles sync (plus debounce when enabled).

## Configuration
- IO_SW_DEBOUNCE_EN defined:
  - Sync output feeds a debouncer.
  - Reported value updates only after the synced value is unchanged for DEBOUNCE_CYCLES consecutive cycles.
  - Any change restarts the count.
- Undefined: reads return the 2-flop synced value directly; DEBOUNCE_CYCLES unused.

## Structure
- Package io_bridge_pkg: state enum, default widths, TIMEOUT and DEBOUNCE_CYCLES defaults, VGA address width 14.
- Sub-module sw_debounce: synchroniser plus optional debounce counter, gated by IO_SW_DEBOUNCE_EN.

## Test plan
- Reset: rst_n low mid-VGA_WAIT → vga_req, ack, led = 0 immediately; IDLE after release.
- LED write then read: write 0x1234_A5A5 with led_sel → led=0xA5A5, ack at N+1, err=0; read returns 64'h0000_A5A5.
- Switch read: sw=0x00F0 held → read after ≥3 cycles returns 0xF0 (no macro). With macro and DEBOUNCE_CYCLES=4: a 2-cycle glitch to 0x0F is not reported.
- VGA read: vga_ack after 5 cycles with vga_rdata=0xDEAD → vga_req high 5 cycles, ack one cycle later, rdata=0xDEAD, err=0.
- VGA timeout: TIMEOUT=8, no vga_ack → vga_req drops after 8 cycles; ack+err=1, rdata=0.
- Unmapped: req with io_sel=1 and no peripheral select → ack at N+1 with err=1, rdata=0; led unchanged.
